// File: rtl/dmem_dump_reader.sv
// Debug read engine for the data memory: walks an address range, reads one word at a time
// and holds each word with its address on registered display outputs (timed or stepped).
module dmem_dump_reader #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 16,
    parameter int HOLD_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] startAdrx,
    input  logic [ADDR_W-1:0] wordCount,
    input  logic              stepMode,
    input  logic              step,
    output logic              rdEn,
    output logic [ADDR_W-1:0] rdAdrx,
    input  logic [DATA_W-1:0] rdData,
    output logic [DATA_W-1:0] dispData,
    output logic [ADDR_W-1:0] dispAdrx,
    output logic              dispValid,
    output logic              busy,
    output logic              done
);

    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0]    HOLD_LOAD = HCW'(HOLD_CYCLES - 1);
    localparam logic [HCW-1:0]    HOLD_ONE  = HCW'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] cur_adrx_r;
    logic [ADDR_W-1:0] remaining_r;
    logic [HCW-1:0]    hold_cnt_r;
    logic              rd_en_r;
    logic [ADDR_W-1:0] rd_adrx_r;
    logic [DATA_W-1:0] disp_data_r;
    logic [ADDR_W-1:0] disp_adrx_r;
    logic              disp_valid_r;
    logic              busy_r;
    logic              done_r;
    logic              leave_hold_s;
    logic [ADDR_W-1:0] next_adrx_s;

    // Decide whether the current HOLD cycle is the last one; mode is sampled every cycle.
    always_comb begin
        leave_hold_s = 1'b0;
        next_adrx_s  = cur_adrx_r + ADDR_ONE;
        if (stepMode) begin
            leave_hold_s = step;
        end else begin
            leave_hold_s = (hold_cnt_r == {HCW{1'b0}});
        end
    end

    // Dump FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cur_adrx_r   <= ADDR_ZERO;
            remaining_r  <= ADDR_ZERO;
            hold_cnt_r   <= {HCW{1'b0}};
            rd_en_r      <= 1'b0;
            rd_adrx_r    <= ADDR_ZERO;
            disp_data_r  <= {DATA_W{1'b0}};
            disp_adrx_r  <= ADDR_ZERO;
            disp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            rd_en_r   <= 1'b0;
            rd_adrx_r <= ADDR_ZERO;
            done_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cur_adrx_r  <= startAdrx;
                        remaining_r <= wordCount;
                        busy_r      <= 1'b1;
                        if (wordCount == ADDR_ZERO) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r   <= ST_READ;
                            rd_en_r   <= 1'b1;
                            rd_adrx_r <= startAdrx;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_READ: begin
                    state_r <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    disp_data_r  <= rdData;
                    disp_adrx_r  <= cur_adrx_r;
                    disp_valid_r <= 1'b1;
                    hold_cnt_r   <= HOLD_LOAD;
                    state_r      <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (leave_hold_s) begin
                        if (remaining_r == ADDR_ONE) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            remaining_r <= remaining_r - ADDR_ONE;
                            cur_adrx_r  <= next_adrx_s;
                            state_r     <= ST_READ;
                            rd_en_r     <= 1'b1;
                            rd_adrx_r   <= next_adrx_s;
                        end
                    end else if (!stepMode) begin
                        hold_cnt_r <= hold_cnt_r - HOLD_ONE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rdEn      = rd_en_r;
    assign rdAdrx    = rd_adrx_r;
    assign dispData  = disp_data_r;
    assign dispAdrx  = disp_adrx_r;
    assign dispValid = disp_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Directed bench for dmem_dump_reader with a behavioural dmem (registered read port).
module tb_dmem_dump_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [10:0] startAdrx = 11'd0;
    logic [10:0] wordCount = 11'd0;
    logic        stepMode = 1'b0;
    logic        step = 1'b0;
    logic        rdEn;
    logic [10:0] rdAdrx;
    logic [15:0] rdData = 16'd0;
    logic [15:0] dispData;
    logic [10:0] dispAdrx;
    logic        dispValid;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:2047];

    int n_cmp = 0;
    int n_bad = 0;

    int          rd_cnt;
    int          rd_cyc [0:7];
    logic [10:0] rd_adr [0:7];
    int          done_cnt;
    int          done_cyc;
    logic [15:0] h_data [0:63];
    logic [10:0] h_adrx [0:63];
    logic        h_busy [0:63];

    dmem_dump_reader #(.ADDR_W(11), .DATA_W(16), .HOLD_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .start(start), .startAdrx(startAdrx),
        .wordCount(wordCount), .stepMode(stepMode), .step(step),
        .rdEn(rdEn), .rdAdrx(rdAdrx), .rdData(rdData),
        .dispData(dispData), .dispAdrx(dispAdrx), .dispValid(dispValid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rdEn) rdData <= mem[rdAdrx];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record activity for n cycles; index c is the c-th cycle after the start edge.
    task automatic run_watch(input int n);
        rd_cnt = 0; done_cnt = 0; done_cyc = -1;
        for (int c = 1; c <= n; c++) begin
            if (rdEn) begin
                if (rd_cnt < 8) begin
                    rd_cyc[rd_cnt] = c;
                    rd_adr[rd_cnt] = rdAdrx;
                end
                rd_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c < 64) begin
                h_data[c] = dispData;
                h_adrx[c] = dispAdrx;
                h_busy[c] = busy;
            end
            tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_rdEn"},      32'(rdEn),      32'd0);
        check_val({tag, "_rdAdrx"},    32'(rdAdrx),    32'd0);
        check_val({tag, "_dispData"},  32'(dispData),  32'd0);
        check_val({tag, "_dispAdrx"},  32'(dispAdrx),  32'd0);
        check_val({tag, "_dispValid"}, 32'(dispValid), 32'd0);
        check_val({tag, "_busy"},      32'(busy),      32'd0);
        check_val({tag, "_done"},      32'(done),      32'd0);
    endtask

    task automatic pulse_start(input logic [10:0] adr, input logic [10:0] cnt);
        startAdrx = adr;
        wordCount = cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Checks a standard 3-word auto dump from address 5 (start edge already taken).
    task automatic check_auto_dump(input string tag);
        run_watch(34);
        check_val({tag, "_rd_cnt"}, 32'(rd_cnt), 32'd3);
        check_val({tag, "_rd0_cyc"}, 32'(rd_cyc[0]), 32'd1);
        check_val({tag, "_rd1_cyc"}, 32'(rd_cyc[1]), 32'd11);
        check_val({tag, "_rd2_cyc"}, 32'(rd_cyc[2]), 32'd21);
        check_val({tag, "_rd0_adr"}, 32'(rd_adr[0]), 32'd5);
        check_val({tag, "_rd2_adr"}, 32'(rd_adr[2]), 32'd7);
        check_val({tag, "_data_c3"}, 32'(h_data[3]), 32'h1111);
        check_val({tag, "_adrx_c3"}, 32'(h_adrx[3]), 32'd5);
        check_val({tag, "_data_c13"}, 32'(h_data[13]), 32'h2222);
        check_val({tag, "_adrx_c13"}, 32'(h_adrx[13]), 32'd6);
        check_val({tag, "_data_c23"}, 32'(h_data[23]), 32'h3333);
        check_val({tag, "_adrx_c23"}, 32'(h_adrx[23]), 32'd7);
        check_val({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check_val({tag, "_done_cyc"}, 32'(done_cyc), 32'd31);
        check_val({tag, "_busy_c31"}, 32'(h_busy[31]), 32'd1);
        check_val({tag, "_busy_c32"}, 32'(h_busy[32]), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'(i ^ 16'h5A00);
        mem[5] = 16'h1111; mem[6] = 16'h2222; mem[7] = 16'h3333;
        mem[2046] = 16'hE0E0; mem[2047] = 16'hF0F0; mem[0] = 16'hA0A0; mem[1] = 16'hB1B1;

        // Reset and idle
        tick(); tick();
        check_all_zero("rst");
        reset = 1'b1;
        run_watch(20);
        check_val("idle_rd_cnt", 32'(rd_cnt), 32'd0);
        check_val("idle_done_cnt", 32'(done_cnt), 32'd0);

        // Auto dump of 5..7
        pulse_start(11'd5, 11'd3);
        check_auto_dump("auto");
        check_val("auto_valid", 32'(dispValid), 32'd1);

        // Wrap-around 2046, 2047, 0
        pulse_start(11'd2046, 11'd3);
        run_watch(34);
        check_val("wrap_rd_cnt", 32'(rd_cnt), 32'd3);
        check_val("wrap_rd0", 32'(rd_adr[0]), 32'd2046);
        check_val("wrap_rd1", 32'(rd_adr[1]), 32'd2047);
        check_val("wrap_rd2", 32'(rd_adr[2]), 32'd0);
        check_val("wrap_done_cnt", 32'(done_cnt), 32'd1);
        check_val("wrap_data", 32'(dispData), 32'hA0A0);
        check_val("wrap_adrx", 32'(dispAdrx), 32'd0);

        // Step mode, with an ignored start while busy
        stepMode = 1'b1;
        pulse_start(11'd0, 11'd2);
        run_watch(50);
        check_val("step_rd_cnt", 32'(rd_cnt), 32'd1);
        check_val("step_adrx", 32'(dispAdrx), 32'd0);
        check_val("step_data", 32'(dispData), 32'hA0A0);
        check_val("step_busy", 32'(busy), 32'd1);
        pulse_start(11'd100, 11'd5);
        check_val("step_xstart_rdEn", 32'(rdEn), 32'd0);
        check_val("step_xstart_busy", 32'(busy), 32'd1);
        step = 1'b1;
        tick();
        step = 1'b0;
        check_val("step1_rdEn", 32'(rdEn), 32'd1);
        check_val("step1_rdAdrx", 32'(rdAdrx), 32'd1);
        tick(); tick();
        check_val("step1_adrx", 32'(dispAdrx), 32'd1);
        check_val("step1_data", 32'(dispData), 32'hB1B1);
        step = 1'b1;
        tick();
        step = 1'b0;
        check_val("step2_done", 32'(done), 32'd1);
        tick();
        check_val("step2_done_end", 32'(done), 32'd0);
        check_val("step2_busy_end", 32'(busy), 32'd0);
        stepMode = 1'b0;

        // Zero word count
        pulse_start(11'd9, 11'd0);
        run_watch(4);
        check_val("zero_done_cyc", 32'(done_cyc), 32'd1);
        check_val("zero_done_cnt", 32'(done_cnt), 32'd1);
        check_val("zero_rd_cnt", 32'(rd_cnt), 32'd0);
        check_val("zero_busy_c1", 32'(h_busy[1]), 32'd1);
        check_val("zero_busy_c2", 32'(h_busy[2]), 32'd0);
        check_val("zero_valid", 32'(dispValid), 32'd1);
        check_val("zero_adrx", 32'(dispAdrx), 32'd1);

        // Reset during the second word's HOLD
        pulse_start(11'd5, 11'd3);
        run_watch(15);
        check_val("mid_busy", 32'(busy), 32'd1);
        check_val("mid_adrx", 32'(dispAdrx), 32'd6);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        tick(); tick();
        reset = 1'b1;
        run_watch(20);
        check_val("post_rst_done", 32'(done_cnt), 32'd0);
        check_val("post_rst_rd", 32'(rd_cnt), 32'd0);
        pulse_start(11'd5, 11'd3);
        check_auto_dump("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_dump_reader.md
# dmem_dump_reader

Read-side debug engine for the 16 x 2k data memory. The CPU writes results into dmem; this block is the matching reader. While the CPU is held, it walks a programmed address range, issues one read per word on the dmem read port, and presents each word with its address on registered display outputs for a fixed dwell time or one manual step at a time. It sits beside the data memory in the board top, sharing the dmem read address through an external mux selected by `busy`.

## Interface
- ADDR_W, 11, dmem address width
- DATA_W, 16, dmem word width
- HOLD_CYCLES, 8, dwell cycles per word in auto mode; must be >= 1
- clk  in  1  system clock, the same clock as the CPU and dmem
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a dump; ignored while busy
- startAdrx  in  ADDR_W  first word address, sampled when start is accepted
- wordCount  in  ADDR_W  number of words to read, sampled with start; 0 completes immediately
- stepMode  in  1  1 = advance only on step, 0 = advance after HOLD_CYCLES
- step  in  1  one-cycle advance request; used in stepMode only
- rdEn  out  1  dmem read strobe
- rdAdrx  out  ADDR_W  dmem read address, valid while rdEn=1
- rdData  in  DATA_W  dmem read data, valid the cycle after rdEn
- dispData  out  DATA_W  last captured word
- dispAdrx  out  ADDR_W  address of dispData
- dispValid  out  1  dispData/dispAdrx hold a word from the current or last dump
- busy  out  1  dump in progress; high from the cycle after start through the DONE cycle
- done  out  1  one-cycle pulse when the dump finishes

## Operation
- State machine states: IDLE, READ, CAPTURE, HOLD, DONE.
- IDLE: if start=1, latch curAdrx<=startAdrx and remaining<=wordCount. If wordCount=0, go to DONE. Otherwise go to READ.
- READ: rdEn=1, rdAdrx=curAdrx. Next state is CAPTURE.
- CAPTURE: dispData<=rdData, dispAdrx<=curAdrx, dispValid<=1, holdCnt<=HOLD_CYCLES-1. Next state is HOLD.
- HOLD, auto mode (stepMode=0): decrement holdCnt. Leave HOLD in the cycle where holdCnt=0.
- HOLD, step mode (stepMode=1): stay until step=1. holdCnt is ignored.
- Leaving HOLD: if remaining=1, go to DONE. Otherwise remaining<=remaining-1, curAdrx<=curAdrx+1 (modulo 2^ADDR_W, so 2047 wraps to 0), and go to READ.
- DONE: done=1 for this single cycle, then go to IDLE.
- stepMode is sampled every HOLD cycle. Switching mode mid-dump takes effect immediately. Switching to auto resumes the existing holdCnt.
- step outside HOLD or with stepMode=0 is ignored. start while busy is ignored.
- dispData, dispAdrx and dispValid retain their values after DONE until the next CAPTURE or reset.
- rdEn=0 and rdAdrx=0 in every state except READ.
- Reset (any time, including mid-dump) returns to IDLE. All outputs go to 0, internal counters clear, and no done pulse is produced.

## Timing
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- With start=1 sampled at edge 0:
  - READ occupies cycle 1 (rdEn=1).
  - CAPTURE occupies cycle 2 (rdData sampled).
  - dispData is updated from cycle 3.
- Auto mode period per word is HOLD_CYCLES+2 cycles. The dump takes N*(HOLD_CYCLES+2) cycles from the first READ, then 1 DONE cycle.
- Step mode: the next READ is in the cycle after step is sampled in HOLD.
- wordCount=0: DONE in cycle 1, done pulse in cycle 1, IDLE in cycle 2. rdEn never asserts.
- busy=1 in cycles READ, CAPTURE, HOLD and DONE.

## Test plan
- Reset and idle: hold reset=0, then release. Required: every output is 0. start=0 for 20 cycles -> rdEn stays 0.
- Auto dump: dmem words 5..7 = 0x1111, 0x2222, 0x3333; HOLD_CYCLES=8, startAdrx=5, wordCount=3, start pulse.
  - Required: rdEn at cycles 1, 11, 21.
  - Required: dispData goes 0x1111 -> 0x2222 -> 0x3333 with dispAdrx 5, 6, 7.
  - Required: done at cycle 31; busy low from cycle 32.
- Wrap-around: startAdrx=2046, wordCount=3. Required: rdAdrx sequence 2046, 2047, 0, then one done pulse.
- Step mode and ignored start: stepMode=1, startAdrx=0, wordCount=2.
  - No step for 50 cycles -> dispAdrx stays 0, busy=1.
  - Extra start pulse during HOLD -> no effect.
  - Step -> READ of address 1 in the next cycle.
  - Second step -> done.
- Zero count: wordCount=0, start. Required: done in cycle 1, rdEn never high, dispValid unchanged.
- Mid-dump reset: assert reset=0 during the second word's HOLD. Required: outputs 0 asynchronously, no done pulse. After release, a new start runs a full dump normally.
